// File: rtl/vend_pkg.sv
// Shared types, default coin/price tables and a lowest-set-bit picker for the
// vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, VEND, PAY} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } pick_t;

  localparam int CW_DEF = 10;

  // Channel/item 0 sits in the least significant slice.
  localparam logic [6*CW_DEF-1:0] COIN_VAL_DEF =
    {10'd100, 10'd50, 10'd25, 10'd10, 10'd5, 10'd1};
  localparam logic [4*CW_DEF-1:0] PRICE_DEF =
    {10'd200, 10'd150, 10'd100, 10'd75};

  function automatic pick_t pick_lowest(input logic [31:0] v);
    pick_t p;
    p = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) begin
        p.valid = 1'b1;
        p.idx   = 5'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change selector: the largest coin whose value does not exceed credit.
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int                  NCOIN    = 6,
  parameter int                  CW       = 10,
  parameter logic [NCOIN*CW-1:0] COIN_VAL = COIN_VAL_DEF
) (
  input  logic [CW-1:0]    credit,
  output logic [NCOIN-1:0] chg,
  output logic [CW-1:0]    val,
  output logic             fit
);

  // Values ascend with index, so the last match wins.
  always_comb begin
    chg = '0;
    val = '0;
    fit = 1'b0;
    for (int k = 0; k < NCOIN; k++) begin
      if (COIN_VAL[k*CW +: CW] <= credit) begin
        chg    = '0;
        chg[k] = 1'b1;
        val    = COIN_VAL[k*CW +: CW];
        fit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit, vend and change controller: accepts coins into a saturating credit,
// grants product requests and pays change or refunds one coin per cycle.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int                  NCOIN    = 6,
  parameter int                  NITEM    = 4,
  parameter int                  CW       = 10,
  parameter logic [NCOIN*CW-1:0] COIN_VAL = COIN_VAL_DEF,
  parameter logic [NITEM*CW-1:0] PRICE    = PRICE_DEF,
  parameter int                  CMAX     = 500
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NCOIN-1:0] coin,
  input  logic [NITEM-1:0] sel,
  input  logic             rr,
  output logic [CW-1:0]    credit,
  output logic [NITEM-1:0] vend,
  output logic [NCOIN-1:0] chg,
  output logic             rej,
  output logic             deny,
  output logic             busy
);

  localparam logic [CW:0] CMAX_W = (CW+1)'(CMAX);

  state_t           state;
  logic [NCOIN-1:0] coin_q;
  logic [NITEM-1:0] sel_q;
  logic             rr_q;
  logic             armed;

  logic [NCOIN-1:0] coin_ev;
  logic [NITEM-1:0] sel_ev;
  logic             rr_ev;
  pick_t            coin_pick;
  pick_t            sel_pick;
  logic [NCOIN-1:0] coin_first;
  logic [CW-1:0]    coin_v;
  logic [NITEM-1:0] sel_oh;
  logic [CW-1:0]    price_v;
  logic [CW:0]      coin_sum;
  logic [NCOIN-1:0] chg_oh;
  logic [CW-1:0]    chg_val;
  logic             chg_fit;

  // The first cycle after reset reports no edges, so a level held through
  // reset must be released and reasserted before it counts.
  assign coin_ev = armed ? (coin & ~coin_q) : '0;
  assign sel_ev  = armed ? (sel & ~sel_q) : '0;
  assign rr_ev   = armed & rr & ~rr_q;

  always_comb begin
    coin_pick  = pick_lowest(32'(coin_ev));
    sel_pick   = pick_lowest(32'(sel_ev));
    coin_first = '0;
    coin_v     = '0;
    for (int i = 0; i < NCOIN; i++) begin
      if (coin_pick.valid && int'(coin_pick.idx) == i) begin
        coin_first[i] = 1'b1;
        coin_v        = COIN_VAL[i*CW +: CW];
      end
    end
    sel_oh  = '0;
    price_v = '0;
    for (int j = 0; j < NITEM; j++) begin
      if (sel_pick.valid && int'(sel_pick.idx) == j) begin
        sel_oh[j] = 1'b1;
        price_v   = PRICE[j*CW +: CW];
      end
    end
    coin_sum = {1'b0, credit} + {1'b0, coin_v};
  end

  vend_change_sel #(
    .NCOIN    (NCOIN),
    .CW       (CW),
    .COIN_VAL (COIN_VAL)
  ) u_change_sel (
    .credit (credit),
    .chg    (chg_oh),
    .val    (chg_val),
    .fit    (chg_fit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      credit <= '0;
      vend   <= '0;
      chg    <= '0;
      rej    <= 1'b0;
      deny   <= 1'b0;
      busy   <= 1'b0;
      coin_q <= '0;
      sel_q  <= '0;
      rr_q   <= 1'b0;
      armed  <= 1'b0;
    end else begin
      coin_q <= coin;
      sel_q  <= sel;
      rr_q   <= rr;
      armed  <= 1'b1;
      vend   <= '0;
      chg    <= '0;
      rej    <= 1'b0;
      deny   <= 1'b0;
      case (state)
        IDLE: begin
          if (rr_ev && credit != '0) begin
            rej <= |coin_ev;
            if (chg_fit) begin
              chg    <= chg_oh;
              credit <= credit - chg_val;
              state  <= PAY;
              busy   <= 1'b1;
            end
          end else if (sel_pick.valid && credit >= price_v) begin
            rej    <= |coin_ev;
            vend   <= sel_oh;
            credit <= credit - price_v;
            state  <= VEND;
            busy   <= 1'b1;
          end else begin
            deny <= sel_pick.valid;
            if (coin_pick.valid && coin_sum <= CMAX_W) begin
              credit <= coin_sum[CW-1:0];
              rej    <= |(coin_ev & ~coin_first);
            end else begin
              rej <= |coin_ev;
            end
          end
        end
        VEND, PAY: begin
          rej <= |coin_ev;
          if (credit != '0 && chg_fit) begin
            chg    <= chg_oh;
            credit <= credit - chg_val;
            state  <= PAY;
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl: transaction-level model with a per-cycle compare,
// directed scenarios pinned by literal expectations, then random traffic.
module tb_vend_credit_ctrl;

  localparam int NCOIN = 6;
  localparam int NITEM = 4;
  localparam int CW    = 10;
  localparam int CMAX  = 500;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [NCOIN-1:0] coin = '0;
  logic [NITEM-1:0] sel = '0;
  logic             rr = 1'b0;
  logic [CW-1:0]    credit;
  logic [NITEM-1:0] vend;
  logic [NCOIN-1:0] chg;
  logic             rej, deny, busy;

  vend_credit_ctrl dut (
    .CLK    (CLK),
    .RST    (RST),
    .coin   (coin),
    .sel    (sel),
    .rr     (rr),
    .credit (credit),
    .vend   (vend),
    .chg    (chg),
    .rej    (rej),
    .deny   (deny),
    .busy   (busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int cval [NCOIN] = '{1, 5, 10, 25, 50, 100};
  int price[NITEM] = '{75, 100, 150, 200};

  // One entry per cycle of a vend/payout sequence still to be output.
  typedef struct {
    int               credit;
    logic [NITEM-1:0] vend;
    logic [NCOIN-1:0] chg;
    bit               busy;
  } rec_t;

  rec_t             q[$];
  int               m_credit = 0;
  logic [NCOIN-1:0] p_coin = '0;
  logic [NITEM-1:0] p_sel = '0;
  logic             p_rr = 1'b0;
  bit               m_armed = 0;
  bit               started = 0;
  int               e_credit = 0;
  logic [NITEM-1:0] e_vend = '0;
  logic [NCOIN-1:0] e_chg = '0;
  bit               e_rej = 0, e_deny = 0, e_busy = 0;

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic push_payout(input int c);
    rec_t r;
    int   k;
    while (c > 0) begin
      k = -1;
      for (int i = 0; i < NCOIN; i++) if (cval[i] <= c) k = i;
      if (k < 0) break;
      c       -= cval[k];
      r.credit = c;
      r.vend   = '0;
      r.chg    = 6'(1) << k;
      r.busy   = 1;
      q.push_back(r);
    end
  endtask

  task automatic push_exit();
    rec_t r;
    r.credit = q[$].credit;
    r.vend   = '0;
    r.chg    = '0;
    r.busy   = 0;
    q.push_back(r);
  endtask

  initial forever begin
    logic [NCOIN-1:0] ce;
    logic [NITEM-1:0] se;
    bit               re;
    rec_t             r;
    int               i, j;
    @(posedge CLK);
    started = 1;
    e_vend = '0; e_chg = '0; e_rej = 0; e_deny = 0; e_busy = 0;
    if (RST) begin
      q.delete();
      m_credit = 0;
      p_coin = '0; p_sel = '0; p_rr = 1'b0;
      m_armed = 0;
    end else begin
      ce = m_armed ? (coin & ~p_coin) : '0;
      se = m_armed ? (sel & ~p_sel) : '0;
      re = m_armed && rr && !p_rr;
      p_coin = coin; p_sel = sel; p_rr = rr;
      m_armed = 1;
      if (q.size() > 0) begin
        r = q.pop_front();
        m_credit = r.credit; e_vend = r.vend; e_chg = r.chg; e_busy = r.busy;
        e_rej = (ce != 0);
      end else begin
        j = lowest(32'(se));
        i = lowest(32'(ce));
        if (re && m_credit > 0) begin
          e_rej = (ce != 0);
          push_payout(m_credit);
          if (q.size() > 0) push_exit();
        end else if (j >= 0 && m_credit >= price[j]) begin
          e_rej = (ce != 0);
          m_credit -= price[j];
          r.credit = m_credit; r.vend = 4'(1) << j; r.chg = '0; r.busy = 1;
          q.push_back(r);
          push_payout(m_credit);
          push_exit();
        end else begin
          e_deny = (j >= 0);
          if (i >= 0) begin
            if (m_credit + cval[i] <= CMAX) begin
              m_credit += cval[i];
              e_rej = ((ce & ~(6'(1) << i)) != 0);
            end else begin
              e_rej = 1;
            end
          end
        end
        if (q.size() > 0) begin
          r = q.pop_front();
          m_credit = r.credit; e_vend = r.vend; e_chg = r.chg; e_busy = r.busy;
        end
      end
    end
    e_credit = m_credit;
  end

  initial forever begin
    @(negedge CLK);
    if (started) begin
      checks++;
      if (credit !== 10'(e_credit) || vend !== e_vend || chg !== e_chg ||
          rej !== e_rej || deny !== e_deny || busy !== e_busy) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t credit %0d/%0d vend %b/%b chg %b/%b rej %b/%b deny %b/%b busy %b/%b (got/exp)",
                 $time, credit, e_credit, vend, e_vend, chg, e_chg, rej, e_rej, deny, e_deny, busy, e_busy);
      end
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic [NCOIN-1:0] c, input logic [NITEM-1:0] s, input logic r);
    coin = c; sel = s; rr = r;
    @(negedge CLK);
  endtask

  task automatic add_coin(input logic [NCOIN-1:0] c);
    drive(c, '0, 1'b0);
    drive('0, '0, 1'b0);
  endtask

  initial begin
    RST = 1'b1;
    drive('0, '0, 0);
    drive('0, '0, 0);
    RST = 1'b0;
    lit("reset_credit", int'(credit), 0);
    lit("reset_busy", int'(busy), 0);
    drive('0, '0, 0);

    drive(6'b100000, '0, 0);
    lit("coin_100", int'(credit), 100);
    drive(6'b010000, '0, 0);
    lit("coin_50", int'(credit), 150);
    drive(6'b001000, '0, 0);
    lit("coin_25", int'(credit), 175);
    repeat (4) drive(6'b001000, '0, 0);
    lit("hold_once", int'(credit), 175);
    drive('0, '0, 0);

    drive('0, 4'b0100, 0);
    lit("vend_pulse", int'(vend), 4);
    lit("vend_credit", int'(credit), 25);
    lit("vend_busy", int'(busy), 1);
    drive('0, 4'b0100, 0);
    lit("vend_chg", int'(chg), 8);
    lit("vend_chg_credit", int'(credit), 0);
    drive('0, '0, 0);
    lit("vend_busy_drop", int'(busy), 0);

    add_coin(6'b010000);
    drive('0, 4'b1000, 0);
    lit("deny_pulse", int'(deny), 1);
    lit("deny_credit", int'(credit), 50);
    lit("deny_novend", int'(vend), 0);
    drive('0, '0, 0);

    repeat (4) add_coin(6'b100000);
    add_coin(6'b001000);
    add_coin(6'b000010);
    lit("cap_build", int'(credit), 480);
    drive(6'b001000, '0, 0);
    lit("cap_rej", int'(rej), 1);
    lit("cap_credit", int'(credit), 480);
    drive('0, '0, 0);
    drive(6'b000011, '0, 0);
    lit("multi_credit", int'(credit), 481);
    lit("multi_rej", int'(rej), 1);
    drive('0, '0, 0);

    RST = 1'b1;
    drive('0, '0, 0);
    RST = 1'b0;
    drive('0, '0, 0);
    add_coin(6'b100000);
    add_coin(6'b010000);
    add_coin(6'b000100);
    add_coin(6'b000010);
    add_coin(6'b000001);
    lit("refund_build", int'(credit), 166);
    drive('0, '0, 1);
    lit("refund_chg100", int'(chg), 32);
    lit("refund_busy", int'(busy), 1);
    drive(6'b000001, '0, 1);
    lit("refund_chg50", int'(chg), 16);
    lit("refund_coin_rej", int'(rej), 1);
    lit("refund_credit16", int'(credit), 16);
    drive('0, '0, 0);
    lit("refund_chg10", int'(chg), 4);
    drive('0, '0, 0);
    lit("refund_chg5", int'(chg), 2);
    drive('0, '0, 0);
    lit("refund_chg1", int'(chg), 1);
    lit("refund_zero", int'(credit), 0);
    drive('0, '0, 0);
    lit("refund_idle", int'(busy), 0);

    add_coin(6'b100000);
    add_coin(6'b100000);
    add_coin(6'b010000);
    drive('0, '0, 1);
    lit("abort_first", int'(credit), 150);
    drive(6'b100000, '0, 0);
    lit("abort_second", int'(credit), 50);
    RST = 1'b1;
    drive(6'b100000, '0, 0);
    lit("abort_credit", int'(credit), 0);
    lit("abort_chg", int'(chg), 0);
    lit("abort_busy", int'(busy), 0);
    RST = 1'b0;
    repeat (3) drive(6'b100000, '0, 0);
    lit("held_after_reset", int'(credit), 0);
    drive('0, '0, 0);
    drive(6'b100000, '0, 0);
    lit("reasserted", int'(credit), 100);
    drive('0, '0, 0);

    repeat (4000) begin
      RST  = ($urandom_range(0, 399) == 0);
      coin = 6'($urandom & $urandom & $urandom);
      sel  = 4'($urandom & $urandom & $urandom & $urandom);
      rr   = ($urandom_range(0, 19) == 0);
      @(negedge CLK);
    end
    RST = 1'b0;
    repeat (20) drive('0, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
